// File: rtl/bitserial_subtractor.sv
// Bit-serial unsigned subtractor: LSB-first full subtractor
// with registered borrow, parallel load and parallel result.
module bitserial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             bnext;
    logic [WIDTH-1:0] res_next;

    // Single-bit full subtractor on the current LSBs.
    always_comb begin
        d        = sa[0] ^ sb[0] ^ br;
        bnext    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        res_next = {d, res[WIDTH-1:1]};
    end

    // Control FSM and datapath registers with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            Bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        br    <= Bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_next;
                    br  <= bnext;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        diff  <= res_next;
                        Bout  <= bnext;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitserial_subtractor.sv
// Scoreboard bench for bitserial_subtractor: driver pushes
// arithmetic expectations, monitor checks on every done.
module tb_bitserial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic [W-1:0] diff;
    logic         Bout;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [W:0] q[$];

    bitserial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .diff (diff),
        .Bout (Bout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(int a, int b, int bin);
        int r;
        logic bo;
        r  = a - b - bin;
        bo = (a < b + bin);
        if (r < 0) r += (1 << W);
        return {bo, r[W-1:0]};
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            logic [W:0] e;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done actual diff=%0d Bout=%0d required no done",
                         diff, Bout);
            end else begin
                e = q.pop_front();
                if ({Bout, diff} != e) begin
                    failures++;
                    $display("FAIL result actual diff=%0d Bout=%0d required diff=%0d Bout=%0d",
                             diff, Bout, e[W-1:0], e[W]);
                end
            end
        end
    end

    task automatic wait_done(output int nbusy, output bit ok);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < 4 * W; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout actual no done required done");
        end
    endtask

    task automatic do_op(int a, int b, int bin, bit timing);
        int  nb;
        bit  ok;
        @(negedge clk);
        A     = W'(a);
        B     = W'(b);
        Bin   = bin[0];
        start = 1'b1;
        q.push_back(model(a, b, bin));
        @(negedge clk);
        start = 1'b0;
        wait_done(nb, ok);
        if (timing && ok) check("busy_cycles", nb, W);
    endtask

    initial begin
        int nb;
        bit ok;
        int last_t;
        int cyc;
        int viol;
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Bin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_diff", diff, 0);
        check("rst_Bout", Bout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        do_op(9, 3, 0, 1'b1);
        do_op(3, 9, 0, 1'b0);
        do_op(5, 5, 1, 1'b0);
        do_op(15, 0, 1, 1'b0);
        do_op(0, 0, 0, 1'b0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    do_op(a, b, c, 1'b0);

        for (int i = 0; i < 40; i++)
            do_op($urandom_range(15), $urandom_range(15),
                  $urandom_range(1), 1'b1);

        // Inputs wiggle and start re-pulses during SHIFT.
        @(negedge clk);
        A     = 4'd13;
        B     = 4'd6;
        Bin   = 1'b1;
        start = 1'b1;
        q.push_back(model(13, 6, 1));
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = i[0];
            A     = W'($urandom);
            B     = W'($urandom);
            Bin   = 1'($urandom);
        end
        @(negedge clk);
        check("ignore_done", done, 1);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("ignore_idle", busy, 0);

        // start held high: a result every W+1 cycles.
        @(negedge clk);
        A      = 4'd12;
        B      = 4'd4;
        Bin    = 1'b0;
        start  = 1'b1;
        q.push_back(model(12, 4, 0));
        last_t = -1;
        cyc    = 0;
        viol   = 0;
        for (int n = 0; n < 3; n++) begin
            ok = 1'b0;
            for (int i = 0; i < 4 * W; i++) begin
                @(negedge clk);
                cyc++;
                if (busy == done) viol++;
                if (done) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL held_timeout actual no done required done");
            end
            if (last_t >= 0) check("held_period", cyc - last_t, W + 1);
            last_t = cyc;
            if (n < 2) q.push_back(model(12, 4, 0));
            else start = 1'b0;
        end
        check("held_busy_vs_done", viol, 0);
        repeat (3) @(negedge clk);

        // Reset during the second SHIFT cycle aborts the op.
        do_op(2, 7, 0, 1'b0);
        @(negedge clk);
        A     = 4'd8;
        B     = 4'd1;
        Bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_Bout", Bout, 0);
        repeat (8) @(negedge clk);
        do_op(8, 1, 0, 1'b1);

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitserial_subtractor.md
Name: bitserial_subtractor

Overview:
Bit-serial unsigned subtractor, the inverse datapath of the team's bit-serial adder. It loads two WIDTH-bit operands in parallel on a start request and shifts them out LSB-first through a single-bit full subtractor with a registered borrow. It shifts difference bits into a result register and presents the parallel difference and final borrow with a one-cycle done pulse. Used wherever a serial add must be undone, or a compare/decrement is needed at minimal area.

Parameters:
WIDTH, 4, operand/result width in bits (≥2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high
start  input  1  request; sampled only in IDLE or DONE
A  input  WIDTH  minuend, sampled on the accepting edge only
B  input  WIDTH  subtrahend, sampled on the accepting edge only
Bin  input  1  borrow-in, sampled on the accepting edge only
diff  output  WIDTH  registered difference (A − B − Bin) mod 2^WIDTH
Bout  output  1  registered borrow-out; 1 iff A < B + Bin (unsigned)
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse: diff/Bout just updated

Behaviour:
- Reset (synchronous, high): state=IDLE; operand, result and borrow registers=0; bit counter=0; diff=0, Bout=0, busy=0, done=0. Reset overrides every other input. Mid-operation reset aborts the operation; no done is produced and outputs read 0 afterwards.
- States: IDLE, SHIFT, DONE. Registered outputs: busy = (state==SHIFT), done = (state==DONE).
- IDLE: start=1 → load sa<=A, sb<=B, br<=Bin, cnt<=0, state<=SHIFT. start=0 → stay.
- SHIFT, one bit per cycle:
  - d = sa[0] ^ sb[0] ^ br; borrow = (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & br).
  - sa, sb shift right; d enters the MSB of the result shift register, which shifts right. br<=borrow; cnt<=cnt+1.
  - On the WIDTH-th SHIFT cycle (cnt==WIDTH-1): diff<=final result including this bit, Bout<=borrow, state<=DONE.
  - start, A, B, Bin are ignored throughout SHIFT.
- DONE (exactly one cycle): start=1 → load as in IDLE and go to SHIFT (back-to-back). Else → IDLE.
- Latency: start accepted at edge k → done high in the cycle following edge k+WIDTH. Throughput with start held high: one result per WIDTH+1 cycles.
- diff and Bout hold their values until the next completion or reset. They are never partially updated during SHIFT.
- Boundaries:
  - A=B, Bin=1 → diff all-ones, Bout=1.
  - A=0, B=0, Bin=0 → diff=0, Bout=0.
  - The wrap-around result is the mod-2^WIDTH value.
- Counter width = clog2(WIDTH) bits; cnt never exceeds WIDTH-1.

Test Plan:
- WIDTH=4, A=9, B=3, Bin=0, start pulse at edge k → done in cycle after edge k+4, diff=6, Bout=0; busy high for exactly 4 cycles.
- A=3, B=9, Bin=0 → diff=10 (0xA), Bout=1. Then A=5, B=5, Bin=1 → diff=15, Bout=1.
- A=15, B=0, Bin=1 → diff=14, Bout=0. A=0, B=0, Bin=0 → diff=0, Bout=0. Exhaustive sweep of all 512 (A,B,Bin) cases vs. the reference model.
- Start pulsed again and A/B/Bin changed during SHIFT → ignored; result matches the originally loaded operands; no extra done.
- start held high with A=12, B=4, Bin=0 → done every 5 cycles, diff=8 each time; busy low only in DONE cycles.
- reset asserted on 2nd SHIFT cycle → next edge: busy=0, diff=0, Bout=0, state IDLE, no done. A new start afterwards completes correctly.
